multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the single-issue RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the instruction/data memory request handshakes, IR latch, register-file write enable and PC update. Control flags come from the instruction decoder and are registered at decode. Memory wait states and a per-access timeout are handled here. An illegal instruction or a timeout parks the core in a sticky halt.

## Interface
- `TIMEOUT`, 15: last wait cycle on which an ack is still accepted in FETCH/MEM. Acks are accepted on wait counts 0..TIMEOUT.
- `CNT_W`, 32: width of the retired-instruction counter.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `o_imemReq`  out  1  instruction fetch request.
- `i_imemAck`  in  1  fetch data valid this cycle.
- `o_irWrite`  out  1  pulse that latches fetch data into the external IR.
- `i_regWrite`, `i_memRead`, `i_memWrite`, `i_illegal`  in  1 each  decoder flags, valid in DECODE.
- `i_PCSrc`  in  2  decoder next-PC select.
- `o_dmemReq`  out  1  data memory request.
- `o_dmemWe`  out  1  data memory write (qualifies `o_dmemReq`).
- `i_dmemAck`  in  1  data access complete.
- `o_regWe`  out  1  register-file write strobe.
- `o_pcWrite`  out  1  PC update strobe.
- `o_pcSel`  out  2  registered PCSrc, valid with `o_pcWrite`.
- `o_state`  out  3  current state encoding.
- `o_fault`  out  1  sticky halt flag.
- `o_faultCause`  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout.
- `o_instret`  out  CNT_W  retired-instruction count.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- **FETCH**
  - `o_imemReq`=1 every cycle in this state.
  - On `i_imemAck`: `o_irWrite`=1 in the same cycle (combinational), next state DECODE.
  - No ack and wait count == TIMEOUT: next state HALT, cause 10.
- **DECODE**
  - `i_illegal` high: next state HALT, cause 01.
  - Otherwise register regWrite, memRead, memWrite and PCSrc into `*_q`; next state EXEC.
- **EXEC**: one cycle. If `memRead_q | memWrite_q`, next state MEM; otherwise WB.
- **MEM**
  - `o_dmemReq`=1, `o_dmemWe`=`memWrite_q`. If read and write are both set, the access is a write.
  - On `i_dmemAck`: next state WB.
  - No ack and wait count == TIMEOUT: next state HALT, cause 11.
- **WB**
  - `o_regWe`=`regWrite_q`, `o_pcWrite`=1, `o_pcSel`=`pcSel_q`.
  - `o_instret`++, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- **HALT**
  - All strobes and requests 0. `o_fault`=1, `o_faultCause` held.
  - Only `i_rst` leaves HALT.
- Wait counter:
  - Clears on every state transition.
  - Increments each FETCH/MEM cycle without ack.
  - Saturates at TIMEOUT.
- Ack arriving in the same cycle as timeout: the ack wins and the access completes normally.
- Acks outside FETCH/MEM are ignored.
- `o_pcSel` holds its value outside WB.

## Timing
- Reset values (registered on the `i_clk` edge with `i_rst`=1):
  - state FETCH; wait counter 0.
  - `*_q` flags 0; `o_pcSel` 00.
  - `o_fault` 0; `o_faultCause` 00; `o_instret` 0.
- While `i_rst`=1, all combinational strobes (`o_imemReq`, `o_irWrite`, `o_dmemReq`, `o_dmemWe`, `o_regWe`, `o_pcWrite`) are forced to 0.
- Reset mid-instruction, including in HALT, abandons the instruction. The cycle after reset deasserts is FETCH with `o_imemReq`=1.
- Zero-wait latency:
  - ALU/branch: 4 cycles per instruction (F, D, E, W).
  - Load/store: 5 cycles (F, D, E, M, W).
- Each wait cycle adds 1 cycle.
- Maximum FETCH or MEM residency is TIMEOUT+1 cycles.
- `o_instret` is visible incremented the cycle after WB.
- Decoder flags are sampled only in DECODE. Changes in other states have no effect.

## Structure
- Shared package `proc_ctrl_pkg`:
  - state encoding constants.
  - fault cause codes.
  - PCSrc encodings shared with the decoder/PC mux.
- Sub-module `wait_timer`: clearable saturating counter, parameter TIMEOUT, output `o_expired`. Instantiated once and cleared on state change.
- FSM next-state logic and output decode live in `multicycle_ctrl`.

## Test plan
- Reset, then an ALU instruction (regWrite=1, mem flags 0), zero-wait imem: states 0,1,2,4,0; `o_regWe` and `o_pcWrite` pulse in cycle 4; `o_instret`=1.
- Store (memWrite=1, regWrite=0), `i_dmemAck` delayed 3 cycles: `o_dmemReq`=`o_dmemWe`=1 for 4 cycles; `o_regWe` stays 0; total 8 cycles.
- `i_imemAck` never asserted, TIMEOUT=15: HALT after 16 FETCH cycles; `o_fault`=1, cause 10; no further requests.
- `i_illegal`=1 in DECODE: HALT, cause 01; `o_instret` unchanged; `i_rst` pulse, then FETCH with `o_fault`=0.
- Load whose ack arrives exactly at wait count 15: WB, not HALT; `o_regWe`=1.
- Preload `o_instret`=2^32-1 by running instructions (or forcing the counter), retire one more: `o_instret`=0.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// halt cause codes and the next-PC selects understood by the PC mux.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JAL    = 2'b10;
  localparam logic [1:0] PCSRC_JALR   = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Clearable saturating wait counter; o_expired marks the last wait cycle
// on which a memory ack is still accepted.
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] MAX = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      count <= '0;
    end else if (i_inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

  assign o_expired = (count == MAX);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory wait-state timeout and a sticky halt on illegal op or timeout.
module multicycle_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic             o_imemReq,
  input  logic             i_imemAck,
  output logic             o_irWrite,
  input  logic             i_regWrite,
  input  logic             i_memRead,
  input  logic             i_memWrite,
  input  logic             i_illegal,
  input  logic [1:0]       i_PCSrc,
  output logic             o_dmemReq,
  output logic             o_dmemWe,
  input  logic             i_dmemAck,
  output logic             o_regWe,
  output logic             o_pcWrite,
  output logic [1:0]       o_pcSel,
  output logic [2:0]       o_state,
  output logic             o_fault,
  output logic [1:0]       o_faultCause,
  output logic [CNT_W-1:0] o_instret
);

  state_t     state, state_nxt;
  logic       reg_write_q, mem_read_q, mem_write_q;
  logic [1:0] pc_sel_q, pc_sel_hold;
  logic [1:0] cause_q, cause_nxt;
  logic       expired, timer_inc;
  logic       imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write;

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    pc_write  = 1'b0;
    timer_inc = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req  = 1'b1;
        timer_inc = ~i_imemAck;
        // Ack is checked before expiry so a last-cycle ack still completes.
        if (i_imemAck) begin
          ir_write  = 1'b1;
          state_nxt = S_DECODE;
        end else if (expired) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (i_illegal) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = (mem_read_q || mem_write_q) ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = mem_write_q;
        timer_inc = ~i_dmemAck;
        if (i_dmemAck) begin
          state_nxt = S_WB;
        end else if (expired) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        reg_we    = reg_write_q;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (state_nxt != state),
    .i_inc     (timer_inc),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_FETCH;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_sel_q    <= PCSRC_PLUS4;
      pc_sel_hold <= PCSRC_PLUS4;
      cause_q     <= CAUSE_NONE;
      o_instret   <= '0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      if (state == S_DECODE && !i_illegal) begin
        reg_write_q <= i_regWrite;
        mem_read_q  <= i_memRead;
        mem_write_q <= i_memWrite;
        pc_sel_q    <= i_PCSrc;
      end
      if (state == S_WB) begin
        o_instret   <= o_instret + CNT_W'(1);
        pc_sel_hold <= pc_sel_q;
      end
    end
  end

  // Strobes are gated by reset so nothing leaks out while the core restarts.
  assign o_imemReq    = imem_req & ~i_rst;
  assign o_irWrite    = ir_write & ~i_rst;
  assign o_dmemReq    = dmem_req & ~i_rst;
  assign o_dmemWe     = dmem_we  & ~i_rst;
  assign o_regWe      = reg_we   & ~i_rst;
  assign o_pcWrite    = pc_write & ~i_rst;
  assign o_pcSel      = (state == S_WB) ? pc_sel_q : pc_sel_hold;
  assign o_state      = state;
  assign o_fault      = (state == S_HALT);
  assign o_faultCause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of instruction records replayed cycle by
// cycle, with a writeback scoreboard and a narrow-counter instance for wrap.
module tb_multicycle_ctrl;
  import proc_ctrl_pkg::*;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
    logic [1:0] pcsrc;
    int         iw;          // imem wait cycles before ack; >TIMEOUT = never
    int         dw;          // dmem wait cycles before ack; >TIMEOUT = never
    int         exp_cycles;  // cycles until WB strobe or first HALT cycle
    logic [1:0] exp_cause;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, illegal = 1'b0;
  logic [1:0]  pc_src = 2'b00;

  logic        imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write, fault;
  logic [1:0]  pc_sel, fault_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        n_imem_req, n_ir_write, n_dmem_req, n_dmem_we, n_reg_we, n_pc_write, n_fault;
  logic [1:0]  n_pc_sel, n_fault_cause;
  logic [2:0]  n_state;
  logic [1:0]  n_instret;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .o_imemReq(imem_req), .i_imemAck(imem_ack),
    .o_irWrite(ir_write), .i_regWrite(reg_write), .i_memRead(mem_read),
    .i_memWrite(mem_write), .i_illegal(illegal), .i_PCSrc(pc_src),
    .o_dmemReq(dmem_req), .o_dmemWe(dmem_we), .i_dmemAck(dmem_ack),
    .o_regWe(reg_we), .o_pcWrite(pc_write), .o_pcSel(pc_sel), .o_state(state),
    .o_fault(fault), .o_faultCause(fault_cause), .o_instret(instret)
  );

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(2)) dut_n (
    .i_clk(clk), .i_rst(rst), .o_imemReq(n_imem_req), .i_imemAck(imem_ack),
    .o_irWrite(n_ir_write), .i_regWrite(reg_write), .i_memRead(mem_read),
    .i_memWrite(mem_write), .i_illegal(illegal), .i_PCSrc(pc_src),
    .o_dmemReq(n_dmem_req), .o_dmemWe(n_dmem_we), .i_dmemAck(dmem_ack),
    .o_regWe(n_reg_we), .o_pcWrite(n_pc_write), .o_pcSel(n_pc_sel), .o_state(n_state),
    .o_fault(n_fault), .o_faultCause(n_fault_cause), .o_instret(n_instret)
  );

  int          errors = 0;
  int          checks = 0;
  logic [2:0]  exp_q[$];
  logic [31:0] exp_instret = '0;
  logic [1:0]  pcsel_hold = 2'b00;
  vec_t        tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_random_flags();
    {reg_write, mem_read, mem_write, illegal} = 4'($urandom_range(0, 15));
    pc_src = 2'($urandom_range(0, 3));
  endtask

  task automatic check_cycle(input state_t st, input logic ai, input vec_t r);
    logic [8:0] exp_v, act_v, act_nv;
    logic [2:0] sb;
    exp_v = {st == S_FETCH, (st == S_FETCH) && ai, st == S_MEM, (st == S_MEM) && r.mem_wr,
             (st == S_WB) && r.reg_we, st == S_WB, st == S_HALT,
             (st == S_HALT) ? r.exp_cause : CAUSE_NONE};
    act_v  = {imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write, fault, fault_cause};
    act_nv = {n_imem_req, n_ir_write, n_dmem_req, n_dmem_we, n_reg_we, n_pc_write, n_fault,
              n_fault_cause};
    check("state", state, st);
    check("strobes", act_v, exp_v);
    check("strobes_narrow", act_nv, exp_v);
    check("pc_sel", pc_sel, (st == S_WB) ? r.pcsrc : pcsel_hold);
    check("instret", instret, exp_instret);
    check("instret_narrow", n_instret, exp_instret[1:0]);
    if (pc_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=pcWrite expected=no_writeback at %0t", $time);
      end else begin
        sb = exp_q.pop_front();
        check("sb_wb", {reg_we, pc_sel}, sb);
      end
    end
    if (st == S_WB) begin
      exp_instret = exp_instret + 32'd1;
      pcsel_hold  = r.pcsrc;
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      drive_random_flags();
      @(negedge clk);
      check("rst_strobes", {imem_req, ir_write, dmem_req, dmem_we, reg_we, pc_write}, 6'b0);
    end
    check("rst_state", state, S_FETCH);
    check("rst_fault", {fault, fault_cause}, 3'b000);
    check("rst_pcsel", pc_sel, 2'b00);
    check("rst_instret", instret, 32'd0);
    check("rst_instret_narrow", n_instret, 2'd0);
    exp_instret = '0;
    pcsel_hold  = 2'b00;
  endtask

  task automatic run_vec(input vec_t r);
    state_t seq[$];
    logic   ai_q[$];
    logic   ad_q[$];
    logic   halts;
    int     end_at;
    int     n;
    halts  = 1'b0;
    end_at = -1;
    n = (r.iw > TIMEOUT) ? TIMEOUT + 1 : r.iw + 1;
    for (int i = 0; i < n; i++) begin
      seq.push_back(S_FETCH); ai_q.push_back(i == r.iw); ad_q.push_back(1'($urandom_range(0, 1)));
    end
    if (r.iw > TIMEOUT) halts = 1'b1;
    if (!halts) begin
      seq.push_back(S_DECODE); ai_q.push_back(1'($urandom_range(0, 1))); ad_q.push_back(1'($urandom_range(0, 1)));
      if (r.illegal) halts = 1'b1;
    end
    if (!halts) begin
      seq.push_back(S_EXEC); ai_q.push_back(1'($urandom_range(0, 1))); ad_q.push_back(1'($urandom_range(0, 1)));
      if (r.mem_rd || r.mem_wr) begin
        n = (r.dw > TIMEOUT) ? TIMEOUT + 1 : r.dw + 1;
        for (int i = 0; i < n; i++) begin
          seq.push_back(S_MEM); ai_q.push_back(1'($urandom_range(0, 1))); ad_q.push_back(i == r.dw);
        end
        if (r.dw > TIMEOUT) halts = 1'b1;
      end
    end
    if (!halts) begin
      seq.push_back(S_WB); ai_q.push_back(1'($urandom_range(0, 1))); ad_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back({r.reg_we, r.pcsrc});
    end else begin
      for (int i = 0; i < 3; i++) begin
        seq.push_back(S_HALT); ai_q.push_back(1'($urandom_range(0, 1))); ad_q.push_back(1'($urandom_range(0, 1)));
      end
    end
    for (int k = 0; k < seq.size(); k++) begin
      @(posedge clk); #1;
      rst      = 1'b0;
      imem_ack = ai_q[k];
      dmem_ack = ad_q[k];
      if (seq[k] == S_DECODE) begin
        {reg_write, mem_read, mem_write, illegal} = {r.reg_we, r.mem_rd, r.mem_wr, r.illegal};
        pc_src = r.pcsrc;
      end else begin
        drive_random_flags();
      end
      @(negedge clk);
      check_cycle(seq[k], ai_q[k], r);
      if (end_at < 0 && (pc_write || fault)) end_at = k + 1;
    end
    check("latency", end_at, r.exp_cycles);
    if (halts) do_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          regW  mrd   mwr   ill   pcsrc         iw  dw  cyc cause
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, PCSRC_PLUS4,  0,  0,  4, CAUSE_NONE};     // ALU
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, PCSRC_PLUS4,  0,  3,  8, CAUSE_NONE};     // store, late ack
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, PCSRC_PLUS4,  2, 15, 22, CAUSE_NONE};     // load, ack at 15
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, PCSRC_BRANCH, 1,  0,  5, CAUSE_NONE};     // branch
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, PCSRC_JALR,   0,  0,  5, CAUSE_NONE};     // rd+wr = write
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, PCSRC_JAL,    0,  0,  4, CAUSE_NONE};     // jal
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, PCSRC_BRANCH, 16, 0, 17, CAUSE_IMEM_TO};  // fetch timeout
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, PCSRC_JALR,   0,  0,  4, CAUSE_NONE};     // ALU
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, PCSRC_JAL,    0,  0,  3, CAUSE_ILLEGAL};  // illegal
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, PCSRC_PLUS4,  0, 16, 20, CAUSE_DMEM_TO};  // dmem timeout

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Reset while fetch is waiting: request must drop and the timer restart.
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    drive_random_flags();
    @(negedge clk);
    check_cycle(S_FETCH, 1'b0, tbl[0]);
    do_reset();

    for (int i = 6; i < 10; i++) run_vec(tbl[i]);

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
